// File: rtl/mouse_ps2_tx.sv
// Host-to-device PS/2 command serializer; owns the data-line drive, bit sequencing and ACK check.
// Optional ACK sampling on the 11th falling edge is enabled by defining PS2_TX_ACK_CHECK_EN.
module mouse_ps2_tx #(
  parameter bit PARITY_ODD = 1'b1
) (
  input  logic       reset,
  input  logic       mouse_clk,
  input  logic       mouse_data,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       data_drive_low,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_ack_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic [7:0] shreg;
  logic [7:0] shreg_nxt;
  logic       cur_bit;
  logic       cur_bit_nxt;
  logic       parity;
  logic       parity_nxt;
  logic       done_nxt;
  logic       ack_err_nxt;
  logic       ack_sample;

`ifdef PS2_TX_ACK_CHECK_EN
  assign ack_sample = mouse_data;
`else
  logic unused_mouse_data;
  assign unused_mouse_data = mouse_data;
  assign ack_sample        = 1'b0;
`endif

  always_ff @(negedge mouse_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      shreg      <= 8'd0;
      cur_bit    <= 1'b1;
      parity     <= 1'b0;
      tx_done    <= 1'b0;
      tx_ack_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shreg      <= shreg_nxt;
      cur_bit    <= cur_bit_nxt;
      parity     <= parity_nxt;
      tx_done    <= done_nxt;
      tx_ack_err <= ack_err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shreg_nxt   = shreg;
    cur_bit_nxt = cur_bit;
    parity_nxt  = parity;
    done_nxt    = tx_done;
    ack_err_nxt = tx_ack_err;
    case (state)
      IDLE: begin
        if (tx_req) begin
          shreg_nxt   = tx_data;
          parity_nxt  = (^tx_data) ^ PARITY_ODD;
          cur_bit_nxt = tx_data[0];
          cnt_nxt     = 4'd1;
          done_nxt    = 1'b0;
          ack_err_nxt = 1'b0;
          state_nxt   = SEND;
        end
      end
      SEND: begin
        if (!tx_req) begin
          // Controller withdrew the request: abandon the frame and release the line.
          state_nxt   = IDLE;
          cnt_nxt     = 4'd0;
          cur_bit_nxt = 1'b1;
          done_nxt    = 1'b0;
          ack_err_nxt = 1'b0;
        end else if (cnt < 4'd8) begin
          shreg_nxt   = shreg >> 1;
          cur_bit_nxt = shreg[1];
          cnt_nxt     = cnt + 4'd1;
        end else if (cnt == 4'd8) begin
          cur_bit_nxt = parity;
          cnt_nxt     = cnt + 4'd1;
        end else if (cnt == 4'd9) begin
          cur_bit_nxt = 1'b1;
          cnt_nxt     = cnt + 4'd1;
        end else begin
          state_nxt   = DONE;
          cnt_nxt     = 4'd0;
          done_nxt    = 1'b1;
          ack_err_nxt = ack_sample;
        end
      end
      DONE: begin
        if (!tx_req) begin
          state_nxt   = IDLE;
          done_nxt    = 1'b0;
          ack_err_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt   = IDLE;
        cnt_nxt     = 4'd0;
        cur_bit_nxt = 1'b1;
        done_nxt    = 1'b0;
        ack_err_nxt = 1'b0;
      end
    endcase
  end

  // Start bit is driven as soon as the request arrives, before the device's first clock.
  assign data_drive_low = ~reset & (((state == IDLE) & tx_req) | ((state == SEND) & ~cur_bit));
  assign tx_busy        = (state == SEND);

endmodule

// File: tb/tb_mouse_ps2_tx.sv
// Directed bench for mouse_ps2_tx: expected data-line drive values are queued per frame and popped per edge.
module tb_mouse_ps2_tx;

  logic       reset;
  logic       mouse_clk;
  logic       mouse_data;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       data_drive_low;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_ack_err;

  int errors = 0;
  int checks = 0;
  logic exp_q[$];

`ifdef PS2_TX_ACK_CHECK_EN
  localparam logic ACK_CHK = 1'b1;
`else
  localparam logic ACK_CHK = 1'b0;
`endif

  mouse_ps2_tx #(.PARITY_ODD(1'b1)) dut (
    .reset          (reset),
    .mouse_clk      (mouse_clk),
    .mouse_data     (mouse_data),
    .tx_req         (tx_req),
    .tx_data        (tx_data),
    .data_drive_low (data_drive_low),
    .tx_busy        (tx_busy),
    .tx_done        (tx_done),
    .tx_ack_err     (tx_ack_err)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Device clock: falling edge, half-period low, rising edge, half-period high.
  task automatic fall();
    mouse_clk = 1'b0;
    #5;
  endtask

  task automatic rise();
    mouse_clk = 1'b1;
    #5;
  endtask

  function automatic logic odd_parity(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  // Raise the request and present the first nedges bits, comparing the pad drive each step.
  task automatic start_frame(input logic [7:0] d, input int nedges, input string name);
    logic seq[11];
    seq[0] = 1'b1;
    for (int i = 0; i < 8; i++) seq[i+1] = ~d[i];
    seq[9]  = ~odd_parity(d);
    seq[10] = 1'b0;
    for (int i = 0; i <= nedges; i++) exp_q.push_back(seq[i]);
    tx_data = d;
    tx_req  = 1'b1;
    #1;
    check({name, "_start"}, {7'd0, data_drive_low}, {7'd0, exp_q.pop_front()});
    #4;
    for (int k = 1; k <= nedges; k++) begin
      fall();
      check($sformatf("%s_edge%0d", name, k), {7'd0, data_drive_low}, {7'd0, exp_q.pop_front()});
      check($sformatf("%s_busy%0d", name, k), {7'd0, tx_busy}, 8'd1);
      rise();
    end
  endtask

  task automatic finish_frame(input logic ack, input logic exp_err, input string name);
    mouse_data = ack;
    fall();
    check({name, "_done"}, {7'd0, tx_done}, 8'd1);
    check({name, "_ackerr"}, {7'd0, tx_ack_err}, {7'd0, exp_err});
    check({name, "_busy_end"}, {7'd0, tx_busy}, 8'd0);
    check({name, "_line_end"}, {7'd0, data_drive_low}, 8'd0);
    rise();
    mouse_data = 1'b1;
  endtask

  task automatic release_done(input string name);
    tx_req = 1'b0;
    fall();
    check({name, "_rel_done"}, {7'd0, tx_done}, 8'd0);
    check({name, "_rel_err"}, {7'd0, tx_ack_err}, 8'd0);
    check({name, "_rel_busy"}, {7'd0, tx_busy}, 8'd0);
    check({name, "_rel_line"}, {7'd0, data_drive_low}, 8'd0);
    rise();
  endtask

  initial begin
    mouse_clk  = 1'b1;
    reset      = 1'b1;
    tx_req     = 1'b1;
    tx_data    = 8'hF4;
    mouse_data = 1'b1;
    #5;
    check("rst_line", {7'd0, data_drive_low}, 8'd0);
    check("rst_done", {7'd0, tx_done}, 8'd0);
    check("rst_busy", {7'd0, tx_busy}, 8'd0);
    check("rst_err", {7'd0, tx_ack_err}, 8'd0);
    fall();
    rise();
    check("rst_edge_busy", {7'd0, tx_busy}, 8'd0);
    reset = 1'b0;
    #1;
    check("rst_rel_start", {7'd0, data_drive_low}, 8'd1);
    tx_req = 1'b0;
    #4;

    // 0xF4 with a good ACK, then response clocks while the request is still held.
    start_frame(8'hF4, 10, "f4");
    finish_frame(1'b0, 1'b0, "f4");
    for (int i = 0; i < 11; i++) begin
      mouse_data = i[0];
      fall();
      check($sformatf("hold_done%0d", i), {7'd0, tx_done}, 8'd1);
      check($sformatf("hold_line%0d", i), {7'd0, data_drive_low}, 8'd0);
      rise();
    end
    mouse_data = 1'b1;
    release_done("f4");

    start_frame(8'h00, 10, "x00");
    finish_frame(1'b0, 1'b0, "x00");
    release_done("x00");

    start_frame(8'hFF, 10, "xff");
    finish_frame(1'b0, 1'b0, "xff");
    release_done("xff");

    start_frame(8'hFF, 10, "nak");
    finish_frame(1'b1, ACK_CHK, "nak");
    release_done("nak");

    start_frame(8'hF4, 10, "f4b");
    finish_frame(1'b0, 1'b0, "f4b");
    release_done("f4b");

    start_frame(8'hA5, 10, "a5");
    finish_frame(1'b0, 1'b0, "a5");
    release_done("a5");

    // Abort by dropping the request after the 4th edge.
    start_frame(8'hF4, 4, "abort");
    tx_req = 1'b0;
    fall();
    check("abort_busy", {7'd0, tx_busy}, 8'd0);
    check("abort_line", {7'd0, data_drive_low}, 8'd0);
    check("abort_done", {7'd0, tx_done}, 8'd0);
    rise();

    // Asynchronous reset mid-frame releases the line without a clock edge.
    start_frame(8'h3C, 6, "arst");
    reset = 1'b1;
    #1;
    check("arst_line", {7'd0, data_drive_low}, 8'd0);
    check("arst_busy", {7'd0, tx_busy}, 8'd0);
    tx_req = 1'b0;
    #2;
    reset = 1'b0;
    #2;
    start_frame(8'hF4, 10, "post_rst");
    finish_frame(1'b0, 1'b0, "post_rst");
    release_done("post_rst");

    check("queue_empty", 8'(exp_q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mouse_ps2_tx.md
Name: mouse_ps2_tx

Overview:
- Host-to-device PS/2 serializer. Sends one command byte to the mouse (e.g. 0xF4 "enable data reporting", 0xFF "reset") over the bidirectional data line.
- Clocked by the device-generated mouse_clk. All state updates happen on the falling edge.
- Companion to the receive-side bit counter.
- A controller in the system-clock domain performs the clock inhibit (≥100 µs) and drives the clock line's open-drain pad. This block owns only the data-line drive, the bit sequencing and the ACK check.

Parameters:
- PARITY_ODD, 1, 1 = odd parity (PS/2 standard); 0 = even parity (test use only).

Ports:
- reset  input  1  asynchronous, active-high
- mouse_clk  input  1  PS/2 clock line (synchronized/filtered upstream); logic acts on the falling edge
- mouse_data  input  1  PS/2 data line as read back from the pad (used for the ACK)
- tx_req  input  1  level request from the controller; held until tx_done or tx_ack_err is seen
- tx_data  input  8  command byte; must be stable while tx_req=1
- data_drive_low  output  1  1 = pull the data pad low (open-drain enable); 0 = release
- tx_busy  output  1  frame in progress
- tx_done  output  1  level; frame completed
- tx_ack_err  output  1  level; device did not ACK (valid only when tx_done=1)

Interface (already decided):
- Reset is named reset: asynchronous, active-high.
- Clock is mouse_clk.

Behaviour:
- Reset state: state=IDLE, cnt=0, shreg=0, cur_bit=1, tx_done=0, tx_ack_err=0, tx_busy=0.
  - data_drive_low is forced to 0 while reset=1.
  - Reset asserted mid-frame aborts immediately and releases the line in the same instant.
- States: IDLE, SEND, DONE. cnt is 4 bits and counts bits presented.
- data_drive_low (combinational):
  - (state==IDLE & tx_req & ~reset) gives the start bit, driven before the first device clock.
  - Or (state==SEND & ~cur_bit).
- tx_busy = (state==SEND).
- IDLE, falling edge:
  - tx_req=1: latch shreg=tx_data, compute parity = ^tx_data XOR PARITY_ODD, cur_bit=tx_data[0], cnt=1, go to SEND.
  - tx_req=0: no change.
- SEND, falling edge k (cnt = k-1 before the edge):
  - cnt 1..7: cur_bit = next data bit, LSB first.
  - cnt==8: cur_bit = parity.
  - cnt==9: cur_bit = 1 (stop bit, line released).
  - cnt increments on each of these edges.
- SEND, cnt==10 (11th falling edge): sample mouse_data (ACK). Then tx_ack_err = mouse_data, tx_done=1, go to DONE.
- SEND, any falling edge with tx_req=0: abort. Go to IDLE, cur_bit=1, tx_done=0, tx_ack_err=0.
- DONE:
  - tx_done and tx_ack_err hold across the mouse's response clocks while tx_req=1.
  - First falling edge with tx_req=0 clears both and returns to IDLE.
- Controller protocol (four-phase):
  1. Pull clock low.
  2. Drop tx_req if it is still high. The inhibit falling edge clears DONE.
  3. Wait ≥100 µs.
  4. Raise tx_req (data goes low combinationally).
  5. Release the clock.
  6. Wait for tx_done.
  7. Drop tx_req.
- tx_req rising while in DONE has no effect until an edge with tx_req=0 has returned the block to IDLE.
- Bits presented per frame: 8 data + parity + stop. Start bit precedes the first edge. Latency from the first device falling edge to tx_done is 11 falling edges.

Optional Feature:
- Macro: PS2_TX_ACK_CHECK_EN.
- Defined: ACK is sampled on the 11th falling edge as described above; tx_ack_err reports 1 when mouse_data=1.
- Undefined: the 11th falling edge goes straight to DONE with tx_done=1. tx_ack_err is tied to 0 and mouse_data is unused.

Test Plan:
- Reset held, tx_req=1 -> data_drive_low=0, tx_done=0, tx_busy=0. Release reset with tx_req=1 -> data_drive_low=1 (start bit).
- Send 0xF4, device ACKs (mouse_data=0 at edge 11) -> line values after edges 1..10 = 0,0,1,0,1,1,1,1, parity 0, stop 1. Then tx_done=1, tx_ack_err=0, tx_busy=0.
- Send 0x00 and 0xFF -> parity bit 1 for both. 0xFF data bits all 1, so data_drive_low=0 during the data phase.
- Send 0xFF, mouse_data=1 at edge 11 (ACK_CHECK_EN defined) -> tx_done=1, tx_ack_err=1. Rebuild without the macro -> tx_ack_err=0.
- After DONE, 11 response clocks with tx_req=1 -> tx_done stays 1. One edge with tx_req=0 -> tx_done=0, state IDLE. Second send of 0xF4 completes normally.
- Abort and reset: drop tx_req after edge 4 -> next edge gives IDLE, data_drive_low=0, tx_done=0. Async reset asserted after edge 6 -> data_drive_low=0 immediately; the next full frame succeeds.
